coin_credit_unit: RTL and testbench

//  Front-end credit stage for the vending machine on Basys 3. Debounces the coin and refund

---
 rtl/vend_pkg.sv | 23 ++
 rtl/coin_credit_unit_if.sv | 30 +++
 rtl/btn_debounce.sv | 55 +++++
 rtl/coin_credit_unit.sv | 198 +++++++++++++++++++
 tb/tb_coin_credit_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions.
//   cc_state_t      : coin/credit unit FSM states (also used by downstream FSMs
//                     that observe the unit's debug state).
//   CC_CREDIT_W     : default credit / price / change width in bits.
//   CC_CREDIT_MAX   : default saturation ceiling for credit.
//   CC_COIN_A_VAL   : default credit units for coin A.
//   CC_COIN_B_VAL   : default credit units for coin B.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD    = 3'd1,
    VEND   = 3'd2,
    HOLD   = 3'd3,
    REFUND = 3'd4
  } cc_state_t;

  localparam int CC_CREDIT_W   = 4;
  localparam int CC_CREDIT_MAX = 15;
  localparam int CC_COIN_A_VAL = 1;
  localparam int CC_COIN_B_VAL = 2;

endpackage

// File: rtl/coin_credit_unit_if.sv
// Vend request handshake between the product-select FSM (master) and the
// coin/credit unit (slave).
//   vend_req   : level, master -> slave. Held high for one purchase attempt.
//   vend_price : master -> slave, sampled together with vend_req.
//   vend_ack   : slave -> master, 1-cycle pulse, purchase accepted.
//   vend_nack  : slave -> master, 1-cycle pulse, insufficient credit.
// Handshake: one request level yields exactly one ack or nack pulse; the
// slave will not accept a new request until vend_req has been seen low.
interface coin_credit_unit_if #(
  parameter int CREDIT_W = 4
);
  logic                vend_req;
  logic [CREDIT_W-1:0] vend_price;
  logic                vend_ack;
  logic                vend_nack;

  modport slave (
    input  vend_req,
    input  vend_price,
    output vend_ack,
    output vend_nack
  );

  modport master (
    output vend_req,
    output vend_price,
    input  vend_ack,
    input  vend_nack
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability counter.
// The debounced level follows the synchronised input only after DB_CYCLES
// consecutive samples that differ from the current level; any sample equal to
// the current level restarts the count.
//   clk, reset  : clock, asynchronous active-high reset
//   btn_raw     : raw asynchronous button input
//   level       : debounced level
//   rise_pulse  : 1-cycle pulse, coincident with level going 0 -> 1
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        // This is the DB_CYCLES-th differing sample in a row.
        cnt        <= '0;
        level      <= sync_q2;
        rise_pulse <= sync_q2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coin_credit_unit.sv
// Coin/credit front end of the vending machine.
// Debounces two coin buttons and a refund button, keeps a saturating credit
// balance, and serves vend requests from the product-select FSM.
// Optional feature: define COIN_CREDIT_TIMEOUT_EN to add an idle timer
// (parameter TIMEOUT_CYCLES) that auto-refunds a non-zero balance after the
// unit has sat in IDLE for TIMEOUT_CYCLES cycles with no press or vend.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   coin_btn[1:0] : raw coin buttons, [0]=coin A, [1]=coin B
//   refund_btn    : raw refund button
//   vend_if       : vend request handshake (slave side)
//   credit        : current balance, registered
//   change_valid  : 1-cycle pulse qualifying change_amt
//   change_amt    : last refunded amount, held until the next refund
//   coin_reject   : 1-cycle pulse, coin would overflow CREDIT_MAX
//   dbg_state     : current FSM state
module coin_credit_unit
  import vend_pkg::*;
#(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int CREDIT_W   = CC_CREDIT_W,
  parameter int CREDIT_MAX = CC_CREDIT_MAX,
  parameter int COIN_A_VAL = CC_COIN_A_VAL,
  parameter int COIN_B_VAL = CC_COIN_B_VAL
`ifdef COIN_CREDIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 32'd3_000_000_000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin_btn,
  input  logic                refund_btn,
  coin_credit_unit_if.slave   vend_if,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output cc_state_t           dbg_state
);

  localparam logic [CREDIT_W-1:0] VAL_A   = CREDIT_W'(COIN_A_VAL);
  localparam logic [CREDIT_W-1:0] VAL_B   = CREDIT_W'(COIN_B_VAL);
  localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W + 1)'(CREDIT_MAX);

  // ---------------------------------------------------------------- buttons
  logic lvl_a, lvl_b, lvl_r;
  logic press_a, press_b, press_r;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk(clk), .reset(reset), .btn_raw(coin_btn[0]), .level(lvl_a), .rise_pulse(press_a)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk(clk), .reset(reset), .btn_raw(coin_btn[1]), .level(lvl_b), .rise_pulse(press_b)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
    .clk(clk), .reset(reset), .btn_raw(refund_btn), .level(lvl_r), .rise_pulse(press_r)
  );

  // Only the edge pulses are consumed here; levels are kept for observability.
  logic unused_levels;
  assign unused_levels = lvl_a ^ lvl_b ^ lvl_r;

  // ---------------------------------------------------------- state and flags
  cc_state_t           state_q, state_d;
  logic                pend_a, pend_b, pend_r;
  logic                clr_a, clr_b, clr_r;
  logic                load_price;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W-1:0] add_val_q, add_val_d;
  logic                timeout_hit;
  logic                ack_q, nack_q;

  assign dbg_state         = state_q;
  assign vend_if.vend_ack  = ack_q;
  assign vend_if.vend_nack = nack_q;

`ifdef COIN_CREDIT_TIMEOUT_EN
  // Idle timer: counts only while sitting in IDLE holding a balance; any
  // press or any excursion out of IDLE (vend, add, refund) restarts it.
  logic [31:0] idle_cnt;
  logic        any_press;

  assign any_press   = press_a | press_b | press_r;
  assign timeout_hit = (idle_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state_q != IDLE || credit == '0 || any_press) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state decode. IDLE priority: refund (incl. timeout) > vend > coin A > coin B.
  always_comb begin
    state_d    = state_q;
    clr_a      = 1'b0;
    clr_b      = 1'b0;
    clr_r      = 1'b0;
    load_price = 1'b0;
    add_val_d  = add_val_q;
    case (state_q)
      IDLE: begin
        if (pend_r || timeout_hit) begin
          state_d = REFUND;
          clr_r   = 1'b1;
        end else if (vend_if.vend_req) begin
          state_d    = VEND;
          load_price = 1'b1;
        end else if (pend_a) begin
          state_d   = ADD;
          clr_a     = 1'b1;
          add_val_d = VAL_A;
        end else if (pend_b) begin
          state_d   = ADD;
          clr_b     = 1'b1;
          add_val_d = VAL_B;
        end
      end
      ADD:     state_d = IDLE;
      VEND:    state_d = HOLD;
      HOLD:    if (!vend_if.vend_req) state_d = IDLE;
      REFUND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A press arriving while its flag is already pending is dropped; a clear
  // only happens with the flag set, so clear-wins also drops a coincident press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      pend_r    <= 1'b0;
      price_q   <= '0;
      add_val_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_a    <= clr_a ? 1'b0 : (pend_a | press_a);
      pend_b    <= clr_b ? 1'b0 : (pend_b | press_b);
      pend_r    <= clr_r ? 1'b0 : (pend_r | press_r);
      add_val_q <= add_val_d;
      if (load_price) price_q <= vend_if.vend_price;
    end
  end

  // ------------------------------------------------------ credit and outputs
  // One bit wider than credit so an overflowing coin is detected, not wrapped.
  logic [CREDIT_W:0] sum;
  assign sum = {1'b0, credit} + {1'b0, add_val_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit       <= '0;
      change_amt   <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
      case (state_q)
        ADD: begin
          if (sum <= MAX_EXT) credit <= sum[CREDIT_W-1:0];
          else                coin_reject <= 1'b1;
        end
        VEND: begin
          if (credit >= price_q) begin
            credit <= credit - price_q;
            ack_q  <= 1'b1;
          end else begin
            nack_q <= 1'b1;
          end
        end
        REFUND: begin
          credit <= '0;
          // An empty refund is silent and leaves the previous change_amt.
          if (credit != '0) begin
            change_amt   <= credit;
            change_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit_unit.sv
module tb_coin_credit_unit;
  import vend_pkg::*;

  localparam int W    = 4;
  localparam int CMAX = 15;

  localparam logic [7:0] EV_ACK  = 8'd1;
  localparam logic [7:0] EV_NACK = 8'd2;
  localparam logic [7:0] EV_CHG  = 8'd3;
  localparam logic [7:0] EV_REJ  = 8'd4;
  localparam logic [7:0] EV_UP   = 8'd5;

  typedef enum int {OP_A, OP_B, OP_R, OP_V} op_t;

  typedef struct {
    op_t op;
    int  price;
    int  credit;
    int  ack;
    int  nack;
    int  rej;
    int  chg;
    int  amt;
  } vec_t;

  // ---------------------------------------------------- clock / reset / DUT
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   coin_btn;
  logic         refund_btn;
  logic [W-1:0] credit;
  logic         change_valid;
  logic [W-1:0] change_amt;
  logic         coin_reject;
  cc_state_t    dbg_state;

  coin_credit_unit_if #(.CREDIT_W(W)) vif ();

  always #5 clk = ~clk;

`ifdef COIN_CREDIT_TIMEOUT_EN
  coin_credit_unit #(.DB_CYCLES(4), .CREDIT_W(W), .CREDIT_MAX(CMAX), .TIMEOUT_CYCLES(50)) dut (
`else
  coin_credit_unit #(.DB_CYCLES(4), .CREDIT_W(W), .CREDIT_MAX(CMAX)) dut (
`endif
    .clk(clk), .reset(reset), .coin_btn(coin_btn), .refund_btn(refund_btn),
    .vend_if(vif.slave), .credit(credit), .change_valid(change_valid),
    .change_amt(change_amt), .coin_reject(coin_reject), .dbg_state(dbg_state)
  );

  // ------------------------------------------------------------ scoreboard
  int pass_cnt  = 0;
  int total_cnt = 0;
  int ack_cnt = 0, nack_cnt = 0, rej_cnt = 0, chg_cnt = 0;
  logic [7:0] ev_log[$];
  logic [7:0] exp_q[$];
  logic [W-1:0] prev_credit = '0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pulse/event monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_credit = '0;
    end else begin
      if (vif.vend_ack)  begin ack_cnt++;  ev_log.push_back(EV_ACK);  end
      if (vif.vend_nack) begin nack_cnt++; ev_log.push_back(EV_NACK); end
      if (coin_reject)   begin rej_cnt++;  ev_log.push_back(EV_REJ);  end
      if (change_valid)  begin chg_cnt++;  ev_log.push_back(EV_CHG);  end
      if (credit > prev_credit) ev_log.push_back(EV_UP);
      prev_credit = credit;
    end
  end

  // --------------------------------------------------------- driver tasks
  task automatic press(input logic a, input logic b, input logic r);
    @(negedge clk);
    coin_btn   = {b, a};
    refund_btn = r;
    repeat (8) @(negedge clk);
    coin_btn   = 2'b00;
    refund_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_vend(input int price, input int hold);
    @(negedge clk);
    vif.vend_price = W'(price);
    vif.vend_req   = 1'b1;
    repeat (hold) @(negedge clk);
    vif.vend_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic apply_op(input op_t op, input int price);
    case (op)
      OP_A:    press(1'b1, 1'b0, 1'b0);
      OP_B:    press(1'b0, 1'b1, 1'b0);
      OP_R:    press(1'b0, 1'b0, 1'b1);
      default: do_vend(price, 6);
    endcase
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int a0, n0, r0, c0;
    a0 = ack_cnt; n0 = nack_cnt; r0 = rej_cnt; c0 = chg_cnt;
    apply_op(v.op, v.price);
    check({tag, " credit"},     int'(credit),     v.credit);
    check({tag, " ack"},        ack_cnt - a0,     v.ack);
    check({tag, " nack"},       nack_cnt - n0,    v.nack);
    check({tag, " reject"},     rej_cnt - r0,     v.rej);
    check({tag, " change"},     chg_cnt - c0,     v.chg);
    check({tag, " change_amt"}, int'(change_amt), v.amt);
  endtask

  // Behavioural reference: plain arithmetic on the credit rules.
  int m_credit, m_amt;
  task automatic model_op(input op_t op, input int price, output vec_t v);
    v = '{op, price, 0, 0, 0, 0, 0, 0};
    case (op)
      OP_A, OP_B: begin
        int val;
        val = (op == OP_A) ? 1 : 2;
        if (m_credit + val <= CMAX) m_credit += val;
        else v.rej = 1;
      end
      OP_R: begin
        if (m_credit != 0) begin v.chg = 1; m_amt = m_credit; end
        m_credit = 0;
      end
      default: begin
        if (m_credit >= price) begin m_credit -= price; v.ack = 1; end
        else v.nack = 1;
      end
    endcase
    v.credit = m_credit;
    v.amt    = m_amt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    vec_t vecs[$];
    vec_t v;
    int   a0, n0, c0, ups, pulses;
    bit   found;

    vecs.push_back('{OP_R, 0,  0, 0, 0, 0, 1,  1});
    for (int i = 1; i <= 7; i++) vecs.push_back('{OP_B, 0, 2 * i, 0, 0, 0, 0, 1});
    vecs.push_back('{OP_B, 0, 14, 0, 0, 1, 0,  1});
    vecs.push_back('{OP_A, 0, 15, 0, 0, 0, 0,  1});
    vecs.push_back('{OP_R, 0,  0, 0, 0, 0, 1, 15});
    vecs.push_back('{OP_A, 0,  1, 0, 0, 0, 0, 15});
    vecs.push_back('{OP_B, 0,  3, 0, 0, 0, 0, 15});
    vecs.push_back('{OP_B, 0,  5, 0, 0, 0, 0, 15});
    vecs.push_back('{OP_V, 3,  2, 1, 0, 0, 0, 15});
    vecs.push_back('{OP_V, 3,  2, 0, 1, 0, 0, 15});
    vecs.push_back('{OP_R, 0,  0, 0, 0, 0, 1,  2});
    vecs.push_back('{OP_R, 0,  0, 0, 0, 0, 0,  2});
    vecs.push_back('{OP_V, 0,  0, 1, 0, 0, 0,  2});

    reset          = 1'b1;
    coin_btn       = 2'b00;
    refund_btn     = 1'b0;
    vif.vend_req   = 1'b0;
    vif.vend_price = '0;
    repeat (3) @(negedge clk);
    check("reset credit",     int'(credit),       0);
    check("reset change_amt", int'(change_amt),   0);
    check("reset pulses",     int'({vif.vend_ack, vif.vend_nack, change_valid, coin_reject}), 0);
    check("reset state",      int'(dbg_state),    int'(IDLE));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset credit", int'(credit), 0);

    // Bouncing coin A: only the final stable level may count.
    ev_log.delete();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      coin_btn[0] = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    coin_btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    coin_btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    ups = 0;
    foreach (ev_log[i]) if (ev_log[i] == EV_UP) ups++;
    check("bounce increments", ups, 1);
    check("bounce credit", int'(credit), 1);
    check("bounce reject", rej_cnt, 0);

    foreach (vecs[i]) run_and_check($sformatf("vec%0d", i), vecs[i]);

    // Long-held request: one ack, then parked in HOLD.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("hold setup credit", int'(credit), 5);
    a0 = ack_cnt; n0 = nack_cnt;
    @(negedge clk);
    vif.vend_price = 4'd3;
    vif.vend_req   = 1'b1;
    repeat (20) @(negedge clk);
    check("hold state", int'(dbg_state), int'(HOLD));
    vif.vend_req = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == IDLE) found = 1;
    end
    check("hold release", int'(found), 1);
    check("hold acks", ack_cnt - a0, 1);
    check("hold nacks", nack_cnt - n0, 0);
    check("hold credit", int'(credit), 2);

    // Refund, vend and coin A all pending together.
    @(negedge clk);
    vif.vend_price = 4'd3;
    vif.vend_req   = 1'b1;
    repeat (4) @(negedge clk);
    press(1'b1, 1'b0, 1'b1);
    check("prio parked", int'(dbg_state), int'(HOLD));
    ev_log.delete();
    vif.vend_req = 1'b0;
    @(negedge clk);
    vif.vend_req = 1'b1;
    repeat (6) @(negedge clk);
    vif.vend_req = 1'b0;
    repeat (8) @(negedge clk);
    exp_q = '{EV_CHG, EV_NACK, EV_UP};
    check("prio event count", ev_log.size(), exp_q.size());
    foreach (exp_q[i]) check($sformatf("prio event%0d", i),
                             (i < ev_log.size()) ? int'(ev_log[i]) : -1, int'(exp_q[i]));
    check("prio credit", int'(credit), 1);
    check("prio change_amt", int'(change_amt), 2);

    // Reset in the middle of a vend.
    a0 = ack_cnt;
    @(negedge clk);
    vif.vend_price = 4'd0;
    vif.vend_req   = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == VEND) found = 1;
    end
    check("reach VEND", int'(found), 1);
    reset = 1'b1;
    #1;
    check("midreset credit",     int'(credit),     0);
    check("midreset change_amt", int'(change_amt), 0);
    check("midreset state",      int'(dbg_state),  int'(IDLE));
    check("midreset pulses",     int'({vif.vend_ack, vif.vend_nack, change_valid, coin_reject}), 0);
    vif.vend_req = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(vif.vend_ack) + int'(vif.vend_nack) + int'(change_valid) + int'(coin_reject);
    end
    check("release pulses", pulses, 0);
    check("midreset acks", ack_cnt - a0, 0);

    // Idle balance: auto-refund only when the timeout feature is built in.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    c0 = chg_cnt;
    repeat (70) @(negedge clk);
`ifdef COIN_CREDIT_TIMEOUT_EN
    check("timeout credit",     int'(credit),     0);
    check("timeout change",     chg_cnt - c0,     1);
    check("timeout change_amt", int'(change_amt), 3);
    m_credit = 0;
    m_amt    = 3;
`else
    check("idle credit",     int'(credit),     3);
    check("idle change",     chg_cnt - c0,     0);
    check("idle change_amt", int'(change_amt), 0);
    m_credit = 3;
    m_amt    = 0;
`endif

    // Randomised sequence against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      op_t op;
      op = op_t'($urandom_range(0, 3));
      model_op(op, int'($urandom_range(0, 15)), v);
      run_and_check($sformatf("rnd%0d", i), v);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
